// File: rtl/byte_pack_loader.sv
// Byte-serial to 64-bit frame packer: eight accepted bytes fill R1/R2 in arrival order,
// then the frame is held with out_valid until the consumer takes it.
module byte_pack_loader #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      R1,
  output logic [31:0]      R2,
  output logic [2:0]       byte_cnt,
  output logic [CNT_W-1:0] frames_done
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [31:0]      r1_q, r1_d;
  logic [31:0]      r2_q, r2_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic             accept;
  logic [4:0]       lane;

  assign in_ready = (state_q == FILL) && !flush;
  assign accept   = in_valid && in_ready;
  // Slot k within a word lands at bit 8*(3-k); ~k gives 3-k for a 2-bit index.
  assign lane     = {~cnt_q[1:0], 3'b000};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    r1_d     = r1_q;
    r2_d     = r2_q;
    frames_d = frames_q;
    if (flush) begin
      state_d = FILL;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            if (cnt_q[2]) begin
              r2_d[lane +: 8] = in_data;
            end else begin
              r1_d[lane +: 8] = in_data;
            end
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              state_d = FULL;
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            state_d  = FILL;
            frames_d = frames_q + CNT_W'(1);
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= FILL;
      cnt_q    <= 3'd0;
      r1_q     <= 32'd0;
      r2_q     <= 32'd0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r1_q     <= r1_d;
      r2_q     <= r2_d;
      frames_q <= frames_d;
    end
  end

  assign out_valid   = (state_q == FULL);
  assign R1          = r1_q;
  assign R2          = r2_q;
  assign byte_cnt    = cnt_q;
  assign frames_done = frames_q;

endmodule

// File: tb/tb_byte_pack_loader.sv
// Self-checking bench for byte_pack_loader: directed vector table, flush corner case,
// and a long randomized run against a frame-level reference model with a scoreboard.
module tb_byte_pack_loader;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] R1, R2;
  logic [2:0]  byte_cnt;
  logic [15:0] frames_done;

  // Narrow-counter twin on the same stimulus so counter wrap is reached quickly.
  logic        inReady2, outValid2;
  logic [31:0] r1Two, r2Two;
  logic [2:0]  byteCnt2;
  logic [2:0]  framesDone2;

  byte_pack_loader #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .R1(R1), .R2(R2), .byte_cnt(byte_cnt), .frames_done(frames_done)
  );

  byte_pack_loader #(.CNT_W(3)) dutWrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(inReady2), .flush(flush), .out_valid(outValid2), .out_ready(out_ready),
    .R1(r1Two), .R2(r2Two), .byte_cnt(byteCnt2), .frames_done(framesDone2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Reference model: frame is a plain byte array filled by index.
  bit          mFull;
  int          mCnt;
  logic [7:0]  mMem [8];
  int unsigned mFrames;
  int          hsCount;
  logic [63:0] sb [$];
  logic        lastRdy;

  typedef struct {
    logic        rstN, vld;
    logic [7:0]  data;
    logic        fl, ordy;
    logic        expRdy, expOv;
    logic [2:0]  expCnt;
    logic [15:0] expFr;
    logic        chkR;
    logic [31:0] expR1, expR2;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t v(logic rstN, logic vld, logic [7:0] data, logic fl, logic ordy,
                             logic expRdy, logic expOv, logic [2:0] expCnt, logic [15:0] expFr,
                             logic chkR, logic [31:0] expR1, logic [31:0] expR2);
    vec_t r;
    r.rstN = rstN; r.vld = vld; r.data = data; r.fl = fl; r.ordy = ordy;
    r.expRdy = expRdy; r.expOv = expOv; r.expCnt = expCnt; r.expFr = expFr;
    r.chkR = chkR; r.expR1 = expR1; r.expR2 = expR2;
    return r;
  endfunction

  function automatic logic [31:0] modelWord(int base);
    return {mMem[base], mMem[base+1], mMem[base+2], mMem[base+3]};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mFull = 0;
    mCnt = 0;
    for (int i = 0; i < 8; i++) mMem[i] = 8'h00;
    mFrames = 0;
    sb.delete();
  endtask

  task automatic checkOutput();
    check("out_valid", 32'(out_valid), 32'(mFull));
    check("byte_cnt", 32'(byte_cnt), 32'(mCnt));
    check("frames_done", 32'(frames_done), 32'(mFrames % 65536));
    check("frames_done_wrap3", 32'(framesDone2), 32'(mFrames % 8));
    check("R1", R1, modelWord(0));
    check("R2", R2, modelWord(4));
  endtask

  task automatic applyStimulus(logic rstN, logic vld, logic [7:0] data, logic fl, logic ordy);
    logic [63:0] expFrame;
    rst_n = rstN; in_valid = vld; in_data = data; flush = fl; out_ready = ordy;
    #1;
    lastRdy = in_ready;
    check("in_ready", 32'(in_ready), 32'(!mFull && !fl));
    if (rstN && !fl && mFull && ordy) begin
      if (sb.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        expFrame = sb.pop_front();
        check("frame_R1", R1, expFrame[63:32]);
        check("frame_R2", R2, expFrame[31:0]);
      end
    end
    @(posedge clk);
    if (!rstN) begin
      modelReset();
    end else if (fl) begin
      if (mFull) void'(sb.pop_front());
      mFull = 0;
      mCnt = 0;
    end else if (!mFull) begin
      if (vld) begin
        mMem[mCnt] = data;
        mCnt++;
        if (mCnt == 8) begin
          mCnt = 0;
          mFull = 1;
          sb.push_back({modelWord(0), modelWord(4)});
        end
      end
    end else if (ordy) begin
      mFull = 0;
      mFrames++;
      hsCount++;
    end
    #1;
    checkOutput();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; flush = 1'b0; out_ready = 1'b0;
    hsCount = 0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();

    // Directed table: reset, fill, stall, handshake, flush mid-frame, reset in FULL.
    vecs.push_back(v(0, 0, 8'h00, 0, 0, 1, 0, 3'd0, 16'd0, 1, 32'h0, 32'h0));
    for (int k = 0; k < 7; k++)
      vecs.push_back(v(1, 1, 8'(8'h11 * (k + 1)), 0, 0, 1, 0, 3'(k + 1), 16'd0, 0, 32'h0, 32'h0));
    vecs.push_back(v(1, 1, 8'h88, 0, 0, 1, 1, 3'd0, 16'd0, 1, 32'h11223344, 32'h55667788));
    for (int k = 0; k < 5; k++)
      vecs.push_back(v(1, k[0], 8'hEE, 0, 0, 0, 1, 3'd0, 16'd0, 1, 32'h11223344, 32'h55667788));
    vecs.push_back(v(1, 1, 8'hEE, 0, 1, 0, 0, 3'd0, 16'd1, 1, 32'h11223344, 32'h55667788));
    vecs.push_back(v(1, 1, 8'hAA, 0, 0, 1, 0, 3'd1, 16'd1, 0, 32'h0, 32'h0));
    vecs.push_back(v(1, 1, 8'hBB, 0, 0, 1, 0, 3'd2, 16'd1, 0, 32'h0, 32'h0));
    vecs.push_back(v(1, 1, 8'hCC, 0, 0, 1, 0, 3'd3, 16'd1, 1, 32'hAABBCC44, 32'h55667788));
    vecs.push_back(v(1, 1, 8'hDD, 1, 0, 0, 0, 3'd0, 16'd1, 1, 32'hAABBCC44, 32'h55667788));
    for (int k = 0; k < 7; k++)
      vecs.push_back(v(1, 1, 8'(k + 1), 0, 0, 1, 0, 3'(k + 1), 16'd1, 0, 32'h0, 32'h0));
    vecs.push_back(v(1, 1, 8'h08, 0, 0, 1, 1, 3'd0, 16'd1, 1, 32'h01020304, 32'h05060708));
    vecs.push_back(v(0, 0, 8'h00, 0, 1, 0, 0, 3'd0, 16'd0, 1, 32'h0, 32'h0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rstN, vecs[i].vld, vecs[i].data, vecs[i].fl, vecs[i].ordy);
      check($sformatf("tbl%0d_in_ready", i), 32'(lastRdy), 32'(vecs[i].expRdy));
      check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].expOv));
      check($sformatf("tbl%0d_byte_cnt", i), 32'(byte_cnt), 32'(vecs[i].expCnt));
      check($sformatf("tbl%0d_frames_done", i), 32'(frames_done), 32'(vecs[i].expFr));
      if (vecs[i].chkR) begin
        check($sformatf("tbl%0d_R1", i), R1, vecs[i].expR1);
        check($sformatf("tbl%0d_R2", i), R2, vecs[i].expR2);
      end
    end

    // Flush while FULL with out_ready high must drop the frame without counting it.
    for (int k = 0; k < 8; k++) applyStimulus(1, 1, 8'(8'hA0 + k), 0, 0);
    check("full_before_flush", 32'(out_valid), 32'd1);
    applyStimulus(1, 0, 8'h00, 1, 1);
    check("flush_full_frames", 32'(frames_done), 32'd0);
    check("flush_full_ovalid", 32'(out_valid), 32'd0);
    check("flush_keeps_R1", R1, 32'hA0A1A2A3);

    // Random gaps, stalls and occasional flushes until 1000 frames complete.
    begin
      int cyc = 0;
      int target = hsCount + 1000;
      while (hsCount < target && cyc < 40000) begin
        applyStimulus(1, $urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 63) == 0,
                      1'($urandom_range(0, 1)));
        cyc++;
      end
      check("random_frames_done_in_budget", 32'(hsCount >= target), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
